// File: rtl/psum_accumulator.sv
// Purpose: accumulates a programmable number of per-column partial-sum rows from the systolic array; optional macro PSUM_ACC_SAT_EN.
// Latency: result is visible in the output holding register one cycle after the final beat of a group is accepted.
// Backpressure: only a group-completing beat stalls, and only while the holding register is full and out_ready is low.
module psum_accumulator #(
   parameter int COL_WIDTH  = 13,
   parameter int ARRAY_SIZE = 8,
   parameter int ACC_WIDTH  = 64,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [ARRAY_SIZE-1:0][COL_WIDTH*4-1:0] psum_in,
   input  logic                                  psum_valid,
   output logic                                  psum_ready,
   input  logic                                  psum_signed,
   input  logic [LEN_WIDTH-1:0]                  acc_len,
   output logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  acc_out,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  busy
`ifdef PSUM_ACC_SAT_EN
   ,
   output logic                                  sat_flag
`endif
);

   localparam int PW = COL_WIDTH * 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   state_t                                r_state;
   logic [LEN_WIDTH-1:0]                  r_len;
   logic [LEN_WIDTH-1:0]                  r_cnt;
   logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  r_acc;
   logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  r_acc_out;
   logic                                  r_out_vld;

   logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  w_ext;
   logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  w_sum;
   logic [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  w_acc_nxt;
   logic [LEN_WIDTH-1:0]                  w_len_new;
   logic [LEN_WIDTH-1:0]                  w_cnt_inc;
   logic                                  w_last;
   logic                                  w_accept;
   logic                                  w_pop;

`ifdef PSUM_ACC_SAT_EN
   logic                                  r_grp_sat;
   logic                                  r_sat_flag;
   logic [ARRAY_SIZE-1:0][ACC_WIDTH:0]    w_full;
   logic [ARRAY_SIZE-1:0]                 w_col_sat;
   logic                                  w_any_sat;
   logic                                  w_grp_sat_nxt;
`endif

   // Length 0 is treated as 1 so a group always completes.
   assign w_len_new = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
   assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);

   // Would the next accepted beat close the current group?
   assign w_last = (r_state == ST_IDLE) ? (w_len_new == LEN_WIDTH'(1))
                                        : (w_cnt_inc == r_len);

   // Only a completing beat needs room in the holding register; a pop on the same edge frees it.
   assign psum_ready = !(r_out_vld && !out_ready && w_last);
   assign w_accept   = psum_valid && psum_ready;
   assign w_pop      = r_out_vld && out_ready;

   // Per-column sign/zero extension of the incoming psum to accumulator width.
   for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_ext
      if (ACC_WIDTH > PW) begin : g_wide
         assign w_ext[c] = {{(ACC_WIDTH-PW){psum_signed & psum_in[c][PW-1]}}, psum_in[c]};
      end else begin : g_same
         assign w_ext[c] = psum_in[c];
      end
   end

`ifdef PSUM_ACC_SAT_EN
   // One extra bit of headroom exposes the unsigned carry-out.
   for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_full
      assign w_full[c] = {1'b0, r_acc[c]} + {1'b0, w_ext[c]};
   end

   // Saturating add: clamp on signed overflow or unsigned carry, per the beat's signedness.
   always_comb begin
      w_any_sat = 1'b0;
      w_sum     = '0;
      w_col_sat = '0;
      for (int c = 0; c < ARRAY_SIZE; c++) begin
         w_sum[c] = w_full[c][ACC_WIDTH-1:0];
         if (psum_signed) begin
            if ((r_acc[c][ACC_WIDTH-1] == w_ext[c][ACC_WIDTH-1]) &&
                (w_full[c][ACC_WIDTH-1] != r_acc[c][ACC_WIDTH-1])) begin
               w_col_sat[c] = 1'b1;
               w_sum[c]     = r_acc[c][ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
         end else if (w_full[c][ACC_WIDTH]) begin
            w_col_sat[c] = 1'b1;
            w_sum[c]     = '1;
         end
         w_any_sat = w_any_sat | w_col_sat[c];
      end
   end

   // A loading beat starts a fresh group with no saturation history.
   assign w_grp_sat_nxt = (r_state == ST_IDLE) ? 1'b0 : (r_grp_sat | w_any_sat);
`else
   // Modular add, wrapping at accumulator width.
   for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_add
      assign w_sum[c] = r_acc[c] + w_ext[c];
   end
`endif

   // First beat of a group loads, later beats add.
   assign w_acc_nxt = (r_state == ST_IDLE) ? w_ext : w_sum;

   // Group FSM with beat counter, accumulators and output holding register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_len     <= LEN_WIDTH'(1);
         r_cnt     <= '0;
         r_acc     <= '0;
         r_acc_out <= '0;
         r_out_vld <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
         r_grp_sat  <= 1'b0;
         r_sat_flag <= 1'b0;
`endif
      end else begin
         if (w_pop) begin
            r_out_vld <= 1'b0;
`ifdef PSUM_ACC_SAT_EN
            r_sat_flag <= 1'b0;
`endif
         end
         if (w_accept) begin
            r_acc <= w_acc_nxt;
`ifdef PSUM_ACC_SAT_EN
            r_grp_sat <= w_grp_sat_nxt;
`endif
            if (w_last) begin
               r_acc_out <= w_acc_nxt;
               r_out_vld <= 1'b1;
`ifdef PSUM_ACC_SAT_EN
               r_sat_flag <= w_grp_sat_nxt;
`endif
            end
            case (r_state)
               ST_IDLE: begin
                  r_len <= w_len_new;
                  if (!w_last) begin
                     r_cnt   <= LEN_WIDTH'(1);
                     r_state <= ST_ACCUM;
                  end
               end
               ST_ACCUM: begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_cnt <= w_cnt_inc;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign acc_out   = r_acc_out;
   assign out_valid = r_out_vld;
   assign busy      = (r_state == ST_ACCUM);
`ifdef PSUM_ACC_SAT_EN
   assign sat_flag  = r_sat_flag;
`endif

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 64-bit-accumulator instance plus a 52-bit one for wrap/saturation.
module tb_psum_accumulator;
   localparam int CW = 13;
   localparam int AS = 8;
   localparam int LW = 16;
   localparam int PW = CW * 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   rst_n;
   logic [AS-1:0][PW-1:0]  psum_in;
   logic                   psum_valid;
   logic                   psum_signed;
   logic [LW-1:0]          acc_len;
   logic                   out_ready;

   logic                   psum_ready, out_valid, busy;
   logic [AS-1:0][63:0]    acc_out;
   logic                   psum_ready_b, out_valid_b, busy_b;
   logic [AS-1:0][51:0]    acc_out_b;
`ifdef PSUM_ACC_SAT_EN
   logic                   sat_flag, sat_flag_b;
`endif

   psum_accumulator #(.COL_WIDTH(CW), .ARRAY_SIZE(AS), .ACC_WIDTH(64), .LEN_WIDTH(LW)) u_dut (
      .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
      .psum_ready(psum_ready), .psum_signed(psum_signed), .acc_len(acc_len),
      .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef PSUM_ACC_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   psum_accumulator #(.COL_WIDTH(CW), .ARRAY_SIZE(AS), .ACC_WIDTH(52), .LEN_WIDTH(LW)) u_dut52 (
      .clk(clk), .rst_n(rst_n), .psum_in(psum_in), .psum_valid(psum_valid),
      .psum_ready(psum_ready_b), .psum_signed(psum_signed), .acc_len(acc_len),
      .acc_out(acc_out_b), .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b)
`ifdef PSUM_ACC_SAT_EN
      , .sat_flag(sat_flag_b)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] sx(input longint v);
      logic [63:0] t;
      t = v;
      return t[PW-1:0];
   endfunction

   task automatic beat(input int col, input logic [PW-1:0] v);
      psum_in      = '0;
      psum_in[col] = v;
      psum_valid   = 1'b1;
   endtask

   task automatic idle;
      psum_in    = '0;
      psum_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      psum_in     = '0;
      psum_valid  = 1'b0;
      psum_signed = 1'b0;
      acc_len     = 16'd1;
      out_ready   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_psum_ready", 64'(psum_ready), 64'd1);
      for (int c = 0; c < AS; c++) check($sformatf("rst_acc_out[%0d]", c), acc_out[c], 64'd0);
      rst_n = 1'b1;

      // Single beat, length 1, zero extension
      acc_len     = 16'd1;
      psum_signed = 1'b0;
      psum_in     = '0;
      psum_in[0]  = sx(5);
      psum_in[1]  = {PW{1'b1}};
      psum_valid  = 1'b1;
      #1;
      check("t1_ready", 64'(psum_ready), 64'd1);
      check("t1_vld_before", 64'(out_valid), 64'd0);
      tick; idle;
      check("t1_vld", 64'(out_valid), 64'd1);
      check("t1_acc0", acc_out[0], 64'd5);
      check("t1_zext", acc_out[1], 64'h000F_FFFF_FFFF_FFFF);
      check("t1_busy", 64'(busy), 64'd0);
      tick;
      check("t1_popped", 64'(out_valid), 64'd0);

      // Signed accumulate with a gap; acc_len change mid-group is ignored
      acc_len     = 16'd4;
      psum_signed = 1'b1;
      beat(3, sx(-7));
      tick;
      check("t2_busy_b1", 64'(busy), 64'd1);
      check("t2_vld_b1", 64'(out_valid), 64'd0);
      acc_len = 16'd1;
      beat(3, sx(3));
      tick; idle;
      check("t2_busy_b2", 64'(busy), 64'd1);
      tick;
      check("t2_busy_gap", 64'(busy), 64'd1);
      check("t2_vld_gap", 64'(out_valid), 64'd0);
      beat(3, sx(10));
      tick;
      check("t2_busy_b3", 64'(busy), 64'd1);
      beat(3, sx(-1));
      tick; idle;
      check("t2_vld", 64'(out_valid), 64'd1);
      check("t2_acc3", acc_out[3], 64'd5);
      check("t2_acc3_52", 64'(acc_out_b[3]), 64'd5);
      check("t2_busy_done", 64'(busy), 64'd0);
      tick;
      check("t2_popped", 64'(out_valid), 64'd0);

      // Backpressure: A completes into a blocked holder, B's final beat stalls
      out_ready   = 1'b0;
      psum_signed = 1'b0;
      acc_len     = 16'd2;
      beat(0, sx(1)); tick;
      beat(0, sx(1)); tick;
      check("t3_a_vld", 64'(out_valid), 64'd1);
      check("t3_a_val", acc_out[0], 64'd2);
      beat(0, sx(2));
      #1;
      check("t3_b1_ready", 64'(psum_ready), 64'd1);
      tick;
      check("t3_b1_busy", 64'(busy), 64'd1);
      #1;
      check("t3_b2_stall", 64'(psum_ready), 64'd0);
      tick;
      check("t3_hold_vld", 64'(out_valid), 64'd1);
      check("t3_hold_val", acc_out[0], 64'd2);
      check("t3_hold_busy", 64'(busy), 64'd1);
      check("t3_still_stall", 64'(psum_ready), 64'd0);
      out_ready = 1'b1;
      #1;
      check("t3_release", 64'(psum_ready), 64'd1);
      tick; idle;
      check("t3_b_vld", 64'(out_valid), 64'd1);
      check("t3_b_val", acc_out[0], 64'd4);
      check("t3_b_busy", 64'(busy), 64'd0);
      tick;
      check("t3_b_popped", 64'(out_valid), 64'd0);

      // acc_len=0 acts as 1, back-to-back groups with no bubbles
      acc_len = 16'd0;
      beat(0, sx(7)); tick;
      check("t4_r0_vld", 64'(out_valid), 64'd1);
      check("t4_r0", acc_out[0], 64'd7);
      beat(0, sx(8)); tick;
      check("t4_r1_vld", 64'(out_valid), 64'd1);
      check("t4_r1", acc_out[0], 64'd8);
      beat(0, sx(9)); tick; idle;
      check("t4_r2_vld", 64'(out_valid), 64'd1);
      check("t4_r2", acc_out[0], 64'd9);
      check("t4_busy", 64'(busy), 64'd0);
      tick;
      check("t4_popped", 64'(out_valid), 64'd0);

      // Reset mid-group with a pending result
      out_ready = 1'b0;
      acc_len   = 16'd1;
      beat(0, sx(3)); tick;
      acc_len = 16'd8;
      beat(0, sx(1)); tick; tick; tick; idle;
      check("t5_pre_busy", 64'(busy), 64'd1);
      check("t5_pre_vld", 64'(out_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_vld", 64'(out_valid), 64'd0);
      check("t5_rst_busy", 64'(busy), 64'd0);
      check("t5_rst_ready", 64'(psum_ready), 64'd1);
      check("t5_rst_acc", acc_out[0], 64'd0);
      tick;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      acc_len   = 16'd1;
      beat(0, sx(11)); tick; idle;
      check("t5_new_vld", 64'(out_valid), 64'd1);
      check("t5_new_val", acc_out[0], 64'd11);
      tick;

      // Overflow: three signed beats of 2^50 into 52- and 64-bit accumulators
      psum_signed = 1'b1;
      acc_len     = 16'd3;
      psum_in     = '0;
      psum_in[0]  = 52'h4_0000_0000_0000;
      psum_in[7]  = sx(1);
      psum_valid  = 1'b1;
      tick; tick; tick; idle;
      check("t6_vld", 64'(out_valid_b), 64'd1);
      check("t6_wide", acc_out[0], 64'h000C_0000_0000_0000);
      check("t6_col7", 64'(acc_out_b[7]), 64'd3);
`ifdef PSUM_ACC_SAT_EN
      check("t6_sat_val", 64'(acc_out_b[0]), 64'h0007_FFFF_FFFF_FFFF);
      check("t6_sat_flag52", 64'(sat_flag_b), 64'd1);
      check("t6_sat_flag64", 64'(sat_flag), 64'd0);
      tick;
      check("t6_sat_clear", 64'(sat_flag_b), 64'd0);
`else
      check("t6_wrap_val", 64'(acc_out_b[0]), 64'h000C_0000_0000_0000);
      tick;
`endif
      check("t6_popped", 64'(out_valid_b), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream neighbour of the systolic array top level.
- Consumes one row of per-column partial sums per beat (ARRAY_SIZE columns, COL_WIDTH*4 bits each).
- Accumulates a programmable number of beats into wide per-column accumulators.
- Presents each finished result in an output holding register with a valid/ready handshake to the writeback path.

Parameters:
- COL_WIDTH, 13, per-column sub-width; each input psum is COL_WIDTH*4 bits.
- ARRAY_SIZE, 8, number of columns.
- ACC_WIDTH, 64, accumulator and output width per column; must be >= COL_WIDTH*4.
- LEN_WIDTH, 16, width of the accumulation-length field.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- psum_in  in  [ARRAY_SIZE-1:0][COL_WIDTH*4-1:0]  partial sums from the array.
- psum_valid  in  1  psum_in is valid this cycle.
- psum_ready  out  1  block can accept a beat this cycle.
- psum_signed  in  1  1 = sign-extend psum_in, 0 = zero-extend; sampled per beat.
- acc_len  in  LEN_WIDTH  beats per result; sampled on the first beat of a group.
- acc_out  out  [ARRAY_SIZE-1:0][ACC_WIDTH-1:0]  completed sums.
- out_valid  out  1  acc_out holds an unconsumed result.
- out_ready  in  1  consumer accepts acc_out.
- busy  out  1  a group is partially accumulated.

Behaviour:
- Reset (async, rst_n=0):
  - acc_out=0, out_valid=0, busy=0, psum_ready=1.
  - Beat counter=0, latched length=1, accumulators=0.
  - Reset mid-group discards the partial group and any pending output.
- Accept: a beat is accepted when psum_valid && psum_ready at posedge.
- Extension: each column psum is extended to ACC_WIDTH (sign or zero per psum_signed of that beat).
- States:
  - IDLE (busy=0) and ACCUM (busy=1).
  - IDLE + accepted beat:
    - Latch len = (acc_len==0) ? 1 : acc_len.
    - Load acc = ext(psum).
    - If len==1: complete the group, stay in IDLE.
    - Else: cnt=1, go to ACCUM.
  - ACCUM + accepted beat:
    - acc = acc + ext(psum), ACC_WIDTH two's-complement wrap.
    - cnt++.
    - If cnt reaches len: complete the group, go to IDLE.
  - acc_len changes during ACCUM are ignored.
- Completion (same edge as the last beat):
  - acc_out <= final sum (including the last beat); out_valid <= 1.
  - Result visible the cycle after the last beat is accepted, i.e. 1-cycle latency.
- Output pop: out_valid && out_ready at posedge clears out_valid, unless a completion occurs on the same edge.
  - In that case acc_out is reloaded and out_valid stays 1; no result is lost or duplicated.
- Backpressure:
  - psum_ready = !(out_valid && !out_ready && next accepted beat would complete a group).
  - Non-final beats are always accepted.
  - A final beat stalls only while the holding register is full and not draining.
  - psum_ready is combinational from state and out_ready, not from psum_valid.
- Gaps: psum_valid=0 cycles inside a group leave acc and cnt unchanged.
- Back-to-back groups: the beat after a completion starts a new group with a load, not an add. There are no bubbles.

Optional Feature:
- Macro: PSUM_ACC_SAT_EN.
- Defined:
  - Every add saturates instead of wrapping.
  - psum_signed=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - psum_signed=0: clamp to [0, 2^ACC_WIDTH-1].
  - Extra output sat_flag (1 bit, reset 0) goes high with out_valid when any column of that result saturated, and clears when the result is popped.
- Undefined: modular wrap on every add; the sat_flag port does not exist.

Test Plan:
- Single beat, length 1: rst_n low for 3 cycles, release; acc_len=1, one beat with column 0 = 5, psum_signed=0 -> acc_out[0]=5, out_valid=1 exactly one cycle after acceptance, busy stays 0.
- Signed accumulate with gaps: acc_len=4, column 3 beats = -7, 3, 10, -1 (psum_signed=1), with one idle cycle between beats 2 and 3 -> acc_out[3]=5, busy=1 from the first beat until completion.
- Backpressure: out_ready=0; complete group A (len 2, values 1, 1), then send group B (len 2, values 2, 2) -> B's first beat is accepted and its second beat stalls (psum_ready=0). Raise out_ready -> A=2 is popped and B=4 loads on the same edge, and out_valid never drops.
- acc_len=0 and back-to-back groups: acc_len=0 with continuous beats 7, 8, 9 -> three results 7, 8, 9 on consecutive cycles with out_ready=1 held.
- Reset mid-group: acc_len=8, three beats accepted, then assert rst_n -> all outputs 0 and psum_ready=1 asynchronously. A new len-1 group with value 11 -> acc_out=11.
- Saturation: PSUM_ACC_SAT_EN defined, ACC_WIDTH=52, signed, len 3, each beat 2^50 -> acc_out=2^51-1 and sat_flag=1. Without the macro -> acc_out=-2^51+2^50 (wrapped).
